// File: rtl/galaksija_tape_pkg.sv
`default_nettype none
// galaksija_tape_pkg: shared state encoding, default tape timing and the pulse-level rule
// for the Galaksija tape player.
package galaksija_tape_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    PLAY  = 2'd3
  } tape_state_t;

  localparam int DEF_PHASE_CYCLES    = 1151;
  localparam int DEF_BYTE_GAP_CYCLES = 13001;
  localparam int DEF_AW              = 14;

  localparam logic [5:0] PREFETCH_PHASE = 6'd62;
  localparam logic [5:0] LAST_PHASE     = 6'd63;

  // Every bit starts with a low pulse; a one adds a second low pulse mid-bit.
  function automatic logic tape_level(input logic [2:0] p, input logic b);
    return !((p == 3'd0) || ((p == 3'd4) && b));
  endfunction

endpackage
`default_nettype wire

// File: rtl/galaksija_tape_pacer.sv
`default_nettype none
// galaksija_tape_pacer: ce-gated phase timer. Each expiry reloads with the normal phase
// length, or with the inter-byte gap length when the next phase is the last of a byte.
module galaksija_tape_pacer
  import galaksija_tape_pkg::*;
#(
  parameter int PHASE_CYCLES    = DEF_PHASE_CYCLES,
  parameter int BYTE_GAP_CYCLES = DEF_BYTE_GAP_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic start,
  input  logic run,
  input  logic gap_next,
  output logic phase_end
);

  localparam int MAXC = (PHASE_CYCLES > BYTE_GAP_CYCLES) ? PHASE_CYCLES : BYTE_GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] PHASE_LOAD = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(BYTE_GAP_CYCLES - 1);

  logic [CW-1:0] count;

  assign phase_end = ce && run && (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (ce) begin
      if (start) begin
        count <= PHASE_LOAD;
      end else if (run) begin
        if (count == '0) count <= gap_next ? GAP_LOAD : PHASE_LOAD;
        else             count <= count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/galaksija_tape_player.sv
`default_nettype none
// galaksija_tape_player: replays a downloaded tape image as Galaksija pulse-coded tape_bit.
// Optional leader frames before the image are enabled by defining GALAKSIJA_TAPE_LEADER_EN.
module galaksija_tape_player
  import galaksija_tape_pkg::*;
#(
  parameter int PHASE_CYCLES    = DEF_PHASE_CYCLES,
  parameter int BYTE_GAP_CYCLES = DEF_BYTE_GAP_CYCLES,
  parameter int AW              = DEF_AW
`ifdef GALAKSIJA_TAPE_LEADER_EN
  ,
  parameter int LEADER_BYTES    = 16
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  output logic [AW-1:0] buf_addr,
  input  logic [7:0]    buf_data,
  output logic          tape_bit,
  output logic          active,
  output logic [AW-1:0] progress,
  output logic [AW-1:0] addr_max
);

`ifdef GALAKSIJA_TAPE_LEADER_EN
  localparam int            LW          = (LEADER_BYTES > 0) ? $clog2(LEADER_BYTES + 1) : 1;
  localparam logic          HAS_LEADER  = (LEADER_BYTES > 0);
  localparam logic [LW-1:0] LEADER_INIT = LW'(LEADER_BYTES);
`else
  localparam int            LW          = 1;
  localparam logic          HAS_LEADER  = 1'b0;
  localparam logic [LW-1:0] LEADER_INIT = '0;
`endif

  tape_state_t   state, next_state;
  logic          dl_prev, wr_seen, start_pending;
  logic          dl_rise, dl_fall, start_req;
  logic [7:0]    shift_reg;
  logic [5:0]    phase;
  logic [LW-1:0] leader_left;
  logic          phase_end, pacer_start, byte_end, in_leader, last_byte;

  assign dl_rise   = ioctl_download & ~dl_prev;
  assign dl_fall   = ~ioctl_download & dl_prev;
  assign start_req = (dl_fall & wr_seen) | start_pending;
  assign byte_end  = phase_end & (phase == LAST_PHASE);
  assign in_leader = (leader_left != '0);
  assign last_byte = (progress == addr_max);

  assign tape_bit = (state == PLAY) ? tape_level(phase[2:0], shift_reg[0]) : 1'b1;
  assign active   = (state != IDLE);

  galaksija_tape_pacer #(
    .PHASE_CYCLES    (PHASE_CYCLES),
    .BYTE_GAP_CYCLES (BYTE_GAP_CYCLES)
  ) u_pacer (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .start     (pacer_start),
    .run       (state == PLAY),
    .gap_next  (phase == PREFETCH_PHASE),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A new download always wins over whatever the replay would have done this cycle.
  always_comb begin
    next_state  = state;
    pacer_start = 1'b0;
    if (dl_rise) begin
      next_state = IDLE;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (start_req) begin
            if (HAS_LEADER) begin
              next_state  = PLAY;
              pacer_start = 1'b1;
            end else begin
              next_state = FETCH;
            end
          end
        end
        FETCH: next_state = LOAD;
        LOAD: begin
          next_state  = PLAY;
          pacer_start = 1'b1;
        end
        PLAY: begin
          if (byte_end) begin
            if (in_leader)      next_state = (leader_left == LW'(1)) ? FETCH : PLAY;
            else if (last_byte) next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_prev       <= 1'b0;
      wr_seen       <= 1'b0;
      start_pending <= 1'b0;
      addr_max      <= '0;
      progress      <= '0;
      buf_addr      <= '0;
      shift_reg     <= '0;
      phase         <= '0;
      leader_left   <= '0;
    end else begin
      dl_prev <= ioctl_download;

      // A falling edge seen while ce is low must not be lost.
      if (dl_rise) begin
        wr_seen       <= 1'b0;
        start_pending <= 1'b0;
      end else if (dl_fall && wr_seen && !ce) begin
        start_pending <= 1'b1;
      end else if (ce) begin
        start_pending <= 1'b0;
      end

      if (ioctl_download && ioctl_wr) begin
        addr_max <= ioctl_addr;
        wr_seen  <= 1'b1;
      end

      if (!dl_rise && ce) begin
        case (state)
          IDLE: begin
            if (start_req) begin
              progress    <= '0;
              buf_addr    <= '0;
              phase       <= '0;
              shift_reg   <= '0;
              leader_left <= LEADER_INIT;
            end
          end
          FETCH: buf_addr <= progress;
          LOAD: begin
            shift_reg <= buf_data;
            phase     <= '0;
          end
          PLAY: begin
            if (phase_end) begin
              phase <= phase + 6'd1;
              if (phase[2:0] == 3'd7) shift_reg <= {1'b0, shift_reg[7:1]};
              if ((phase == PREFETCH_PHASE) && !in_leader) buf_addr <= progress + 1'b1;
              if (phase == LAST_PHASE) begin
                if (in_leader) begin
                  leader_left <= leader_left - LW'(1);
                  shift_reg   <= '0;
                end else if (!last_byte) begin
                  progress  <= progress + 1'b1;
                  shift_reg <= buf_data;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
